// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the 16-bit processor.
// Owns the program counter, drives the combinational instruction memory
// address, and queues fetched words (with their PC) in a 2-entry FIFO toward
// decode. Handles branch/jump redirects and stops fetching after a HALT word.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   start           leave IDLE and begin fetching from the current PC
//   imem_addr       instruction memory address (always the PC register)
//   imem_instr      word returned combinationally for imem_addr
//   if_valid        queue head is valid
//   if_ready        decode takes the head this cycle
//   if_instr/if_pc  head instruction and the address it came from
//   redirect_valid  taken branch/jump: flush queue, load redirect_pc
//   redirect_pc     redirect target
//   halted          HALT state with an empty queue
//   fetch_count     number of pushes since reset (wraps)
module fetch_ctrl #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter logic [3:0]  HALT_OP  = 4'b1111,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [15:0] if_instr,
    output logic [7:0]  if_pc,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam logic [1:0] Full = DEPTH[1:0];

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] fcnt_q, fcnt_d;
    // Entry 0 is always the head; entry 1 shifts down on a pop.
    logic [15:0] e0_instr_q, e0_instr_d, e1_instr_q, e1_instr_d;
    logic [7:0]  e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;

    logic       pop, space, push, flush;
    logic [1:0] base;

    assign pop   = (cnt_q != 2'd0) && if_ready;
    assign space = (cnt_q < Full) || pop;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        fcnt_d     = fcnt_q;
        e0_instr_d = e0_instr_q;
        e0_pc_d    = e0_pc_q;
        e1_instr_d = e1_instr_q;
        e1_pc_d    = e1_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        base       = 2'd0;

        unique case (state_q)
            StIdle: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (start) state_d = StRun;
            end
            StRun: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                end else if (space) begin
                    push   = 1'b1;
                    pc_d   = pc_q + 8'd1;
                    fcnt_d = fcnt_q + 16'd1;
                    if (imem_instr[15:12] == HALT_OP) state_d = StHalt;
                end
            end
            StHalt: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_d    = redirect_pc;
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase

        // A pop coinciding with a flush is still delivered; the flush just
        // empties whatever remains. Entry contents are kept so the outputs
        // hold their last values while empty.
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            if (pop && (cnt_q == 2'd2)) begin
                e0_instr_d = e1_instr_q;
                e0_pc_d    = e1_pc_q;
            end
            base = cnt_q - {1'b0, pop};
            if (push) begin
                if (base == 2'd0) begin
                    e0_instr_d = imem_instr;
                    e0_pc_d    = pc_q;
                end else begin
                    e1_instr_d = imem_instr;
                    e1_pc_d    = pc_q;
                end
            end
            cnt_d = base + {1'b0, push};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            cnt_q      <= 2'd0;
            fcnt_q     <= 16'd0;
            e0_instr_q <= 16'd0;
            e0_pc_q    <= 8'd0;
            e1_instr_q <= 16'd0;
            e1_pc_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            fcnt_q     <= fcnt_d;
            e0_instr_q <= e0_instr_d;
            e0_pc_q    <= e0_pc_d;
            e1_instr_q <= e1_instr_d;
            e1_pc_q    <= e1_pc_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_valid    = (cnt_q != 2'd0);
    assign if_instr    = e0_instr_q;
    assign if_pc       = e0_pc_q;
    assign halted      = (state_q == StHalt) && (cnt_q == 2'd0);
    assign fetch_count = fcnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl. Each row gives the inputs
// held across one rising edge and the outputs expected just after it.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, if_ready, redirect_valid;
    logic [7:0]  redirect_pc, imem_addr, if_pc;
    logic [15:0] imem_instr, if_instr, fetch_count;
    logic        if_valid, halted;

    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr];

    fetch_ctrl #(
        .RESET_PC (8'h00),
        .HALT_OP  (4'b1111),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    typedef struct {
        logic        rst, start, rdy, rv;
        logic [7:0]  rpc;
        logic        e_valid;
        logic [7:0]  e_pc;
        logic [15:0] e_instr;
        logic [7:0]  e_addr;
        logic        e_halted;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic rdy, input logic rv,
                       input logic [7:0] rpc, input logic ev, input logic [7:0] epc,
                       input logic [15:0] ei, input logic [7:0] ea, input logic eh,
                       input logic [15:0] ec);
        vec_t v;
        v.rst = r; v.start = s; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_valid = ev; v.e_pc = epc; v.e_instr = ei; v.e_addr = ea;
        v.e_halted = eh; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'h5000 | 16'(a);
        mem[0] = 16'h1123;  // ADD
        mem[1] = 16'h2123;  // SUB
        mem[2] = 16'h3456;  // LW
        mem[3] = 16'h4789;  // SW
        mem[4] = 16'hF000;  // HALT

        rst = 1'b1; start = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 8'h00;

        //   rst st rdy rv rpc    valid pc     instr     addr   hlt cnt
        add(1, 0, 0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 0, 0);
        // Straight-line program to HALT with decode always ready
        add(0, 1, 1, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 0, 0);
        add(0, 0, 1, 0, 8'h00, 1, 8'h00, 16'h1123, 8'h01, 0, 1);
        add(0, 0, 1, 0, 8'h00, 1, 8'h01, 16'h2123, 8'h02, 0, 2);
        add(0, 0, 1, 0, 8'h00, 1, 8'h02, 16'h3456, 8'h03, 0, 3);
        add(0, 0, 1, 0, 8'h00, 1, 8'h03, 16'h4789, 8'h04, 0, 4);
        add(0, 0, 1, 0, 8'h00, 1, 8'h04, 16'hF000, 8'h05, 0, 5);
        add(0, 0, 1, 0, 8'h00, 0, 8'h04, 16'hF000, 8'h05, 1, 5);
        // start in HALT is ignored; redirect resumes at 0x10
        add(0, 1, 1, 0, 8'h00, 0, 8'h04, 16'hF000, 8'h05, 1, 5);
        add(0, 0, 1, 1, 8'h10, 0, 8'h04, 16'hF000, 8'h10, 0, 5);
        add(0, 0, 1, 0, 8'h00, 1, 8'h10, 16'h5010, 8'h11, 0, 6);
        add(0, 0, 0, 0, 8'h00, 1, 8'h10, 16'h5010, 8'h12, 0, 7);
        add(0, 0, 0, 0, 8'h00, 1, 8'h10, 16'h5010, 8'h12, 0, 7);
        // Reset with two queued entries, then IDLE until start
        add(1, 0, 1, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 0, 0);
        add(0, 0, 1, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 0, 0);
        // Back-pressure: queue fills, then drains in order
        add(0, 1, 0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 0, 0);
        add(0, 0, 0, 0, 8'h00, 1, 8'h00, 16'h1123, 8'h01, 0, 1);
        add(0, 0, 0, 0, 8'h00, 1, 8'h00, 16'h1123, 8'h02, 0, 2);
        add(0, 0, 0, 0, 8'h00, 1, 8'h00, 16'h1123, 8'h02, 0, 2);
        add(0, 0, 1, 0, 8'h00, 1, 8'h01, 16'h2123, 8'h03, 0, 3);
        add(0, 0, 1, 0, 8'h00, 1, 8'h02, 16'h3456, 8'h04, 0, 4);
        add(0, 0, 1, 0, 8'h00, 1, 8'h03, 16'h4789, 8'h05, 0, 5);
        add(0, 0, 1, 0, 8'h00, 1, 8'h04, 16'hF000, 8'h05, 0, 5);
        add(0, 0, 1, 0, 8'h00, 0, 8'h04, 16'hF000, 8'h05, 1, 5);
        // Redirect while full with a pop: pc1 must never appear
        add(1, 0, 0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 0, 0);
        add(0, 1, 0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 0, 0);
        add(0, 0, 0, 0, 8'h00, 1, 8'h00, 16'h1123, 8'h01, 0, 1);
        add(0, 0, 0, 0, 8'h00, 1, 8'h00, 16'h1123, 8'h02, 0, 2);
        add(0, 0, 1, 1, 8'h40, 0, 8'h00, 16'h1123, 8'h40, 0, 2);
        add(0, 0, 0, 0, 8'h00, 1, 8'h40, 16'h5040, 8'h41, 0, 3);
        add(0, 0, 1, 0, 8'h00, 1, 8'h41, 16'h5041, 8'h42, 0, 4);
        // Redirect to 0xFE: PC wraps through 0xFF to 0x00, then runs to HALT
        add(0, 0, 1, 1, 8'hFE, 0, 8'h41, 16'h5041, 8'hFE, 0, 4);
        add(0, 0, 1, 0, 8'h00, 1, 8'hFE, 16'h50FE, 8'hFF, 0, 5);
        add(0, 0, 1, 0, 8'h00, 1, 8'hFF, 16'h50FF, 8'h00, 0, 6);
        add(0, 0, 1, 0, 8'h00, 1, 8'h00, 16'h1123, 8'h01, 0, 7);
        add(0, 0, 1, 0, 8'h00, 1, 8'h01, 16'h2123, 8'h02, 0, 8);
        add(0, 0, 1, 0, 8'h00, 1, 8'h02, 16'h3456, 8'h03, 0, 9);
        add(0, 0, 1, 0, 8'h00, 1, 8'h03, 16'h4789, 8'h04, 0, 10);
        add(0, 0, 1, 0, 8'h00, 1, 8'h04, 16'hF000, 8'h05, 0, 11);
        add(0, 0, 1, 0, 8'h00, 0, 8'h04, 16'hF000, 8'h05, 1, 11);
        // IDLE: redirect+start loads PC and runs; redirect alone stays IDLE
        add(1, 0, 1, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 0, 0);
        add(0, 1, 1, 1, 8'h20, 0, 8'h00, 16'h0000, 8'h20, 0, 0);
        add(0, 0, 1, 0, 8'h00, 1, 8'h20, 16'h5020, 8'h21, 0, 1);
        add(1, 0, 1, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 0, 0);
        add(0, 0, 1, 1, 8'h30, 0, 8'h00, 16'h0000, 8'h30, 0, 0);
        add(0, 0, 1, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h30, 0, 0);
        add(0, 1, 1, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h30, 0, 0);
        add(0, 0, 1, 0, 8'h00, 1, 8'h30, 16'h5030, 8'h31, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst            = vecs[i].rst;
            start          = vecs[i].start;
            if_ready       = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(posedge clk);
            #1;
            check("if_valid", i, {15'd0, if_valid}, {15'd0, vecs[i].e_valid});
            check("if_pc", i, {8'd0, if_pc}, {8'd0, vecs[i].e_pc});
            check("if_instr", i, if_instr, vecs[i].e_instr);
            check("imem_addr", i, {8'd0, imem_addr}, {8'd0, vecs[i].e_addr});
            check("halted", i, {15'd0, halted}, {15'd0, vecs[i].e_halted});
            check("fetch_count", i, fetch_count, vecs[i].e_cnt);
        end

        // Free-running program: wait (bounded) for halted after draining
        begin
            int n;
            rst = 1'b1; start = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b0; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            n = 0;
            while (!halted && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("halt_wait", -1, {15'd0, halted}, 16'd1);
            check("halt_cycles", -1, 16'(n), 16'd6);
            check("halt_count", -1, fetch_count, 16'd5);
            check("halt_pc", -1, {8'd0, if_pc}, 16'h0004);
            check("halt_valid", -1, {15'd0, if_valid}, 16'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
